// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: state encoding, default
// geometry and the settle-counter width helper.
package mux_scan_ctrl_pkg;

    localparam int unsigned DEF_SEL_W  = 2;
    localparam int unsigned DEF_SETTLE = 1;

    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_SETTLE = 2'd1,
        MS_SAMPLE = 2'd2,
        MS_DONE   = 2'd3
    } ms_state_e;

    // A zero settle time still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned settle);
        return (settle == 0) ? 1 : (($clog2(settle + 1) < 1) ? 1 : $clog2(settle + 1));
    endfunction

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Loadable down-counter that times the settle interval after each select change.
module mux_scan_settle_cnt #(
    parameter int unsigned W      = 1,
    parameter int unsigned RELOAD = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam logic [W-1:0] RELOAD_V = W'(RELOAD);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD_V;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 2**SEL_W:1 mux through every select value and assembles the sampled
// word. Define MUX_SCAN_PARITY_EN to add a registered even-parity output.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SEL_W  = DEF_SEL_W,
    parameter int unsigned SETTLE = DEF_SETTLE,
    localparam int unsigned N_IN  = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             f_in,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             data_valid,
    output logic [N_IN-1:0]  data
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int unsigned      CNT_W    = cnt_width(SETTLE);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_IN - 1);

    ms_state_e        state_q;
    logic [SEL_W-1:0] sel_q;
    logic             busy_q;
    logic             dv_q;
    logic [N_IN-1:0]  shadow_q;
    logic [N_IN-1:0]  data_q;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    always_comb begin
        cnt_load = ((state_q == MS_IDLE) && start) ||
                   ((state_q == MS_SAMPLE) && (sel_q != SEL_LAST));
        cnt_dec  = (state_q == MS_SETTLE) && !cnt_zero;
    end

    mux_scan_settle_cnt #(
        .W      (CNT_W),
        .RELOAD (SETTLE)
    ) u_settle_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero)
    );

`ifdef MUX_SCAN_PARITY_EN
    logic parity_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MS_IDLE;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            dv_q     <= 1'b0;
            shadow_q <= '0;
            data_q   <= '0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                MS_IDLE: begin
                    if (start) begin
                        state_q <= MS_SETTLE;
                        busy_q  <= 1'b1;
                    end
                end
                MS_SETTLE: begin
                    if (cnt_zero) begin
                        state_q <= MS_SAMPLE;
                    end
                end
                MS_SAMPLE: begin
                    shadow_q[sel_q] <= f_in;
                    // sel returns to 0 as DONE is entered so it never sits past the last input.
                    if (sel_q == SEL_LAST) begin
                        state_q <= MS_DONE;
                        sel_q   <= '0;
                    end else begin
                        state_q <= MS_SETTLE;
                        sel_q   <= sel_q + SEL_W'(1);
                    end
                end
                MS_DONE: begin
                    data_q  <= shadow_q;
                    dv_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    sel_q   <= '0;
                    state_q <= MS_IDLE;
`ifdef MUX_SCAN_PARITY_EN
                    parity_q <= ^shadow_q;
`endif
                end
                default: begin
                    state_q <= MS_IDLE;
                end
            endcase
        end
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign data_valid = dv_q;
    assign data       = data_q;
`ifdef MUX_SCAN_PARITY_EN
    assign parity     = parity_q;
`endif

endmodule
